// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared defaults and types for the sdp_array read path
package sram_pkg;

  localparam int SDP_WIDTH_DEF = 32;
  localparam int DEPTH_DEF     = 2048;
  localparam int WIDTH_DEF     = 96 * 8;
  localparam int ADDR_BITS_DEF = $clog2(DEPTH_DEF);

  typedef logic [ADDR_BITS_DEF-1:0] sram_addr_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] data;
    logic                 last;
  } rd_beat_t;

endpackage

// File: rtl/skid_fifo.sv
// rtl/skid_fifo.sv - small register FIFO with registered empty/full flags
module skid_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic empty_o,
  output logic full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i & ~empty_q;
  // A full FIFO may still accept a push in the same cycle it pops.
  assign do_push = push_i & (~full_q | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= bump(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= bump(rd_ptr_q);
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/sdp_stream_reader.sv
// rtl/sdp_stream_reader.sv - command-driven port-B reader of sdp_array with credit-gated stream output
module sdp_stream_reader
  import sram_pkg::*;
#(
  parameter  int WIDTH      = WIDTH_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  parameter  int SDP_WIDTH  = SDP_WIDTH_DEF,
  localparam int BITS_DEPTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [BITS_DEPTH-1:0] cmd_addr,
  input  logic [BITS_DEPTH-1:0] cmd_len,
  output logic                  enb,
  output logic [BITS_DEPTH-1:0] addrb,
  input  logic [WIDTH-1:0]      doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last
);

  localparam int FIFO_DEPTH = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  if (WIDTH % SDP_WIDTH != 0) begin : g_bad_width
    $error("sdp_stream_reader: WIDTH must be a multiple of SDP_WIDTH");
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic [0:0]            state_q, state_d;
  logic [BITS_DEPTH-1:0] rd_addr_q, rd_addr_d;
  logic [BITS_DEPTH-1:0] rem_q, rem_d;
  logic [1:0]            credits_q, credits_d;
  logic [1:0]            cred_after;
  logic                  pending_push_q, pending_last_q;
  logic                  issue, pop;
  logic                  fifo_empty, fifo_full;
  beat_t                 capture, head;

  assign pop        = m_valid & m_ready;
  // Credits cover both the read in flight and beats held in the FIFO.
  assign cred_after = credits_q - {1'b0, pop};
  assign issue      = (state_q == ST_READ) && (cred_after < 2'(FIFO_DEPTH));

  assign cmd_ready = (state_q == ST_IDLE);
  assign enb       = issue;
  assign addrb     = rd_addr_q;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rem_d     = rem_q;
    credits_d = credits_q + {1'b0, issue} - {1'b0, pop};
    if (state_q == ST_IDLE) begin
      if (cmd_valid) begin
        rd_addr_d = cmd_addr;
        rem_d     = cmd_len;
        state_d   = ST_READ;
      end
    end else if (issue) begin
      rd_addr_d = (rd_addr_q == BITS_DEPTH'(DEPTH - 1)) ? '0 : rd_addr_q + 1'b1;
      if (rem_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        rem_d = rem_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      rd_addr_q      <= '0;
      rem_q          <= '0;
      credits_q      <= '0;
      pending_push_q <= 1'b0;
      pending_last_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_addr_q      <= rd_addr_d;
      rem_q          <= rem_d;
      credits_q      <= credits_d;
      pending_push_q <= issue;
      pending_last_q <= issue & (rem_q == '0);
    end
  end

  assign capture = '{data: doutb, last: pending_last_q};

  skid_fifo #(
    .T     (beat_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .push_i  (pending_push_q),
    .data_i  (capture),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // The credit limit means a capture never lands on a full FIFO that is not draining.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(pending_push_q && fifo_full && !pop));
    end
  end

  assign m_valid = ~fifo_empty;
  assign m_data  = head.data;
  assign m_last  = head.last;

endmodule

// File: tb/tb_sdp_stream_reader.sv
// tb/tb_sdp_stream_reader.sv - scoreboard bench for sdp_stream_reader against a behavioural array model
module tb_sdp_stream_reader;

  localparam int WIDTH = 768;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_s;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_addr = '0;
  logic [AW-1:0]    cmd_len = '0;
  logic             enb;
  logic [AW-1:0]    addrb;
  logic [WIDTH-1:0] doutb;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  beat_s exp_beats[$];
  int    exp_addr[$];
  int    pop_cyc[$];
  int    cyc = 0;
  int    issued = 0;
  int    popped = 0;
  int    checks = 0;
  int    errors = 0;
  int    mode = 0;

  sdp_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SDP_WIDTH(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .enb       (enb),
    .addrb     (addrb),
    .doutb     (doutb),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  function automatic logic [WIDTH-1:0] row_val(input int r);
    logic [31:0] w;
    w = 32'(r * 3 + 1);
    return {24{w}};
  endfunction

  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Preloaded array: one-cycle read latency on port B.
  always @(posedge clk) begin
    if (enb) doutb <= row_val(int'(addrb));
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : monitor
    beat_s e;
    int    a;
    int    p;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_beats.delete();
        exp_addr.delete();
        issued = 0;
        popped = 0;
      end else begin
        p = (m_valid && m_ready) ? 1 : 0;
        if (enb) begin
          check((issued - popped - p) < 2,
                $sformatf("credit enb with outstanding %0d pop %0d (limit 2)", issued - popped, p));
          check(exp_addr.size() != 0, $sformatf("extra_enb addrb %0d with none expected", addrb));
          if (exp_addr.size() != 0) begin
            a = exp_addr.pop_front();
            check(int'(addrb) == a, $sformatf("addrb got %0d want %0d", addrb, a));
          end
          issued++;
        end
        if (p == 1) begin
          check(exp_beats.size() != 0, $sformatf("stale_beat data %h last %0d", m_data[31:0], m_last));
          if (exp_beats.size() != 0) begin
            e = exp_beats.pop_front();
            check(m_data == e.data, $sformatf("beat_data got %h want %h", m_data[31:0], e.data[31:0]));
            check(m_last == e.last, $sformatf("beat_last got %0d want %0d", m_last, e.last));
          end
          pop_cyc.push_back(cyc);
          popped++;
        end
      end
    end
  end

  task automatic send_cmd(input int addr, input int len);
    beat_s b;
    int    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(cmd_ready, $sformatf("cmd_ready_wait got %0d want 1", cmd_ready));
    cmd_valid = 1'b1;
    cmd_addr  = AW'(addr);
    cmd_len   = AW'(len);
    for (int i = 0; i <= len; i++) begin
      exp_addr.push_back((addr + i) % DEPTH);
      b.data = row_val((addr + i) % DEPTH);
      b.last = (i == len);
      exp_beats.push_back(b);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while (!(exp_beats.size() == 0 && exp_addr.size() == 0 && cmd_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(n < 3000, $sformatf("drain_timeout beats left %0d addrs left %0d", exp_beats.size(), exp_addr.size()));
  endtask

  initial begin : stimulus
    int base;
    int i0;
    int n;

    #12;
    check(cmd_ready == 1'b1, $sformatf("reset cmd_ready got %0d want 1", cmd_ready));
    check(enb == 1'b0 && addrb == '0, $sformatf("reset enb/addrb got %0d/%0d want 0/0", enb, addrb));
    check(m_valid == 1'b0 && m_last == 1'b0, $sformatf("reset m_valid/m_last got %0d/%0d want 0/0", m_valid, m_last));
    check(m_data == '0, $sformatf("reset m_data got %h want 0", m_data[31:0]));
    @(negedge clk);
    #1 rstn = 1'b1;

    // Basic 4-beat read at full throughput, with cycle-accurate latency.
    mode = 0;
    send_cmd(0, 3);
    @(negedge clk);
    check(enb && addrb == 0, $sformatf("lat c1 enb/addrb got %0d/%0d want 1/0", enb, addrb));
    check(!m_valid, $sformatf("lat c1 m_valid got %0d want 0", m_valid));
    @(negedge clk);
    check(!m_valid, $sformatf("lat c2 m_valid got %0d want 0", m_valid));
    @(negedge clk);
    check(m_valid, $sformatf("lat c3 m_valid got %0d want 1", m_valid));
    @(negedge clk);
    check(!cmd_ready, $sformatf("lat c4 cmd_ready got %0d want 0", cmd_ready));
    @(negedge clk);
    check(cmd_ready, $sformatf("lat c5 cmd_ready got %0d want 1", cmd_ready));
    wait_drain();

    // Alternating backpressure.
    mode = 1;
    send_cmd(0, 3);
    wait_drain();
    mode = 0;

    // Address wrap.
    send_cmd(2046, 3);
    wait_drain();

    // Single beat.
    i0 = issued;
    send_cmd(5, 0);
    wait_drain();
    check(issued - i0 == 1, $sformatf("single enb count got %0d want 1", issued - i0));

    // Back-to-back commands: exactly one bubble between them.
    base = pop_cyc.size();
    send_cmd(0, 1);
    send_cmd(100, 1);
    wait_drain();
    check(pop_cyc.size() >= base + 4, $sformatf("b2b beats got %0d want 4", pop_cyc.size() - base));
    if (pop_cyc.size() >= base + 4) begin
      check(pop_cyc[base+1] - pop_cyc[base] == 1, $sformatf("b2b gap0 got %0d want 1", pop_cyc[base+1] - pop_cyc[base]));
      check(pop_cyc[base+2] - pop_cyc[base+1] == 2, $sformatf("b2b gap1 got %0d want 2", pop_cyc[base+2] - pop_cyc[base+1]));
      check(pop_cyc[base+3] - pop_cyc[base+2] == 1, $sformatf("b2b gap2 got %0d want 1", pop_cyc[base+3] - pop_cyc[base+2]));
    end

    // Asynchronous reset in the middle of a long command.
    base = pop_cyc.size();
    send_cmd(10, 7);
    n = 0;
    while (pop_cyc.size() < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(n < 100, $sformatf("reset_wait beats got %0d want 2", pop_cyc.size() - base));
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check(!m_valid && !enb && !m_last, $sformatf("async_rst m_valid/enb/m_last got %0d/%0d/%0d want 0/0/0", m_valid, enb, m_last));
    check(cmd_ready, $sformatf("async_rst cmd_ready got %0d want 1", cmd_ready));
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check(!m_valid && !enb && cmd_ready,
            $sformatf("post_rst m_valid/enb/cmd_ready got %0d/%0d/%0d want 0/0/1", m_valid, enb, cmd_ready));
    end

    // Randomised commands with random backpressure, issued back to back.
    mode = 2;
    for (int k = 0; k < 25; k++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2036, 2047)) : int'($urandom_range(0, DEPTH - 1));
      send_cmd(a, int'($urandom_range(0, 15)));
    end
    wait_drain();
    mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
